// File: rtl/axi_pkg.sv
// Shared definitions for the AXI write-data drain: FSM encoding, length width
// and the byte-strobe width derivation.
package axi_pkg;

  localparam int AXI_LEN_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    STREAM    = 2'd1,
    LAST_WAIT = 2'd2
  } drain_state_t;

  function automatic int strb_width(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/w_out_stage.sv
// W-channel output register: holds valid/data/last until the beat is accepted,
// reloading directly from the FIFO head when a new beat is loaded.
module w_out_stage #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  load,
  input  logic                  accept,
  input  logic                  last_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  last
);

  // A load wins over an accept so back-to-back beats keep valid high.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      valid <= 1'b0;
      data  <= '0;
      last  <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= data_in;
      last  <= last_in;
    end else if (accept) begin
      valid <= 1'b0;
      last  <= 1'b0;
    end
  end

endmodule

// File: rtl/axi_w_drain.sv
// Drains the write-data FIFO into AXI W beats, one burst of cmd_len+1 beats
// per accepted command, with wlast on the final beat.
module axi_w_drain
  import axi_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = AXI_LEN_WIDTH
) (
  input  logic                                clk,
  input  logic                                clr,
  input  logic                                cmd_valid,
  output logic                                cmd_ready,
  input  logic [LEN_WIDTH-1:0]                cmd_len,
  input  logic                                fifo_empty,
  input  logic [DATA_WIDTH-1:0]               fifo_head,
  output logic                                fifo_read_en,
  output logic                                wvalid,
  input  logic                                wready,
  output logic [DATA_WIDTH-1:0]               wdata,
  output logic [strb_width(DATA_WIDTH)-1:0]   wstrb,
  output logic                                wlast,
  output logic                                busy
);

  drain_state_t         state;
  drain_state_t         next_state;
  logic [LEN_WIDTH:0]   remaining;
  logic                 load;
  logic                 accept;
  logic                 last_load;

  assign accept       = wvalid & wready;
  assign load         = (state == STREAM) & ~fifo_empty & (~wvalid | wready);
  assign last_load    = (remaining == (LEN_WIDTH + 1)'(1));
  assign fifo_read_en = load;
  assign cmd_ready    = (state == IDLE);
  assign wstrb        = '1;

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:      if (cmd_valid) next_state = STREAM;
      STREAM:    if (load && last_load) next_state = LAST_WAIT;
      LAST_WAIT: if (accept) next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // remaining is one bit wider than cmd_len so a 256-beat burst fits.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state     <= IDLE;
      remaining <= '0;
      busy      <= 1'b0;
    end else begin
      state <= next_state;
      busy  <= (next_state != IDLE);
      if (cmd_valid && cmd_ready) begin
        remaining <= {1'b0, cmd_len} + (LEN_WIDTH + 1)'(1);
      end else if (load) begin
        remaining <= remaining - (LEN_WIDTH + 1)'(1);
      end
    end
  end

  w_out_stage #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out (
    .clk     (clk),
    .clr     (clr),
    .load    (load),
    .accept  (accept),
    .last_in (last_load),
    .data_in (fifo_head),
    .valid   (wvalid),
    .data    (wdata),
    .last    (wlast)
  );

endmodule
